// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: writeback wins, long-latency results queue and drain on idle
// cycles, with a busy scoreboard and starvation stall. Optional same-cycle bypass: WB_ARB_BYPASS_EN.
`ifndef XLEN_64b
`define XLEN_64b 2
`endif

module wb_port_arbiter #(
    parameter int unsigned XLEN         = `XLEN_64b,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 8,
    localparam int unsigned W  = 1 << (XLEN + 4),
    localparam int unsigned PW = $clog2(FIFO_DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clk_enable,
    input  logic          i_wb_valid,
    input  logic [4:0]    i_wb_addr,
    input  logic [W-1:0]  i_wb_data,
    input  logic          i_lu_issue,
    input  logic [4:0]    i_lu_issue_addr,
    input  logic          i_lu_valid,
    input  logic [4:0]    i_lu_addr,
    input  logic [W-1:0]  i_lu_data,
    output logic          o_lu_ready,
    input  logic [4:0]    i_rs1_addr,
    input  logic [4:0]    i_rs2_addr,
    output logic          o_busy_rs1,
    output logic          o_busy_rs2,
    output logic          o_rf_we,
    output logic [4:0]    o_rf_addr,
    output logic [W-1:0]  o_rf_data,
    output logic          o_pipe_stall,
    output logic [CW-1:0] o_fifo_count
);

    logic [4:0]    fifo_addr_q [FIFO_DEPTH];
    logic [W-1:0]  fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   busy_q, busy_d;
    logic [7:0]    starve_q, starve_d;

    logic          empty, full, push, pop, bypass, bypass_wr;
    logic          grant;
    logic [4:0]    gnt_addr;
    logic [W-1:0]  gnt_data;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(FIFO_DEPTH));

`ifdef WB_ARB_BYPASS_EN
    assign bypass = i_lu_valid & empty & ~i_wb_valid;
`else
    assign bypass = 1'b0;
`endif

    assign bypass_wr  = bypass & i_clk_enable;
    assign pop        = i_clk_enable & ~i_wb_valid & ~empty;
    assign push       = i_clk_enable & i_lu_valid & ~full & ~bypass;
    assign o_lu_ready = ~full;

    always_comb begin
        grant    = 1'b0;
        gnt_addr = '0;
        gnt_data = '0;
        if (i_wb_valid) begin
            grant    = 1'b1;
            gnt_addr = i_wb_addr;
            gnt_data = i_wb_data;
        end else if (!empty) begin
            grant    = 1'b1;
            gnt_addr = fifo_addr_q[rd_ptr_q];
            gnt_data = fifo_data_q[rd_ptr_q];
        end else if (bypass) begin
            grant    = 1'b1;
            gnt_addr = i_lu_addr;
            gnt_data = i_lu_data;
        end
    end

    // Reset gating keeps a discarded queue head from reaching the register file.
    assign o_rf_we   = grant & i_clk_enable & ~i_rst & (gnt_addr != 5'd0);
    assign o_rf_addr = gnt_addr;
    assign o_rf_data = gnt_data;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Set is applied last so it wins over a same-cycle clear.
    always_comb begin
        busy_d = busy_q;
        if (pop) busy_d[fifo_addr_q[rd_ptr_q]] = 1'b0;
        if (bypass_wr) busy_d[i_lu_addr] = 1'b0;
        if (i_clk_enable && i_lu_issue && (i_lu_issue_addr != 5'd0)) begin
            busy_d[i_lu_issue_addr] = 1'b1;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (i_clk_enable) begin
            if (pop || empty) begin
                starve_d = '0;
            end else if (i_wb_valid && (starve_q != 8'(STARVE_LIMIT))) begin
                starve_d = starve_q + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            starve_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            starve_q <= starve_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= i_lu_addr;
            fifo_data_q[wr_ptr_q] <= i_lu_data;
        end
    end

    assign o_busy_rs1   = busy_q[i_rs1_addr];
    assign o_busy_rs2   = busy_q[i_rs2_addr];
    assign o_pipe_stall = full | (starve_q == 8'(STARVE_LIMIT));
    assign o_fifo_count = count_q;

endmodule
